fetch_invalidate_controller: RTL
================================

Name: fetch_invalidate_controller

Overview:
Sequences instruction-side invalidation requests (FENCE.I → I-cache, SFENCE.VMA → TLB) issued by the execute stage. Halts the fetch unit and waits for it to drain. Then walks every I-cache tag index, clearing it, and flushes the I-TLB. Finally signals completion back to execute. Sits between the execute stage and the fetch unit, and owns the I-cache tag-array invalidate port and the TLB flush port.

Parameters:
INDEX_WIDTH, 6, I-cache line-index width; the walk covers 2**INDEX_WIDTH lines.

Ports:
clk  input  1  core clock
rstN  input  1  reset, asynchronous assert, active-low
reqICache  input  1  one-cycle request pulse from execute: invalidate I-cache
reqTlb  input  1  one-cycle request pulse from execute: flush I-TLB
busy  output  1  controller not IDLE; execute stalls on it
done  output  1  one-cycle pulse when a sequence completes
fetchHalt  output  1  request to fetch unit to stop issuing new accesses
fetchIdle  input  1  fetch unit has no outstanding miss/refill
iCacheInvValid  output  1  invalidate request for iCacheInvIndex
iCacheInvIndex  output  INDEX_WIDTH  line index being invalidated
iCacheInvReady  input  1  tag array accepted the invalidate this cycle
tlbFlush  output  1  TLB flush request, held until acknowledged
tlbFlushDone  input  1  TLB flush complete (single-cycle ack)

Behaviour:
- Reset: all outputs 0, state IDLE, index counter 0, pending bits 0.
- pendICache/pendTlb:
  - set on the corresponding req pulse in any state.
  - cleared when the matching phase is entered.
  - set and clear in the same cycle → set wins.
- States:
  - IDLE → DRAIN when (pendICache|pendTlb|reqICache|reqTlb). A request in IDLE therefore causes busy=1 on the next cycle.
  - DRAIN: fetchHalt=1. When fetchIdle=1 → INV_ICACHE if pendICache, else FLUSH_TLB.
  - INV_ICACHE: fetchHalt=1, iCacheInvValid=1, iCacheInvIndex=counter.
    - On iCacheInvReady the counter increments, wrapping to 0.
    - When counter==all-ones and ready → FLUSH_TLB if pendTlb, else DONE.
    - Counter is 0 on entry.
    - Exactly 2**INDEX_WIDTH accepted invalidates, in ascending order; no skips or duplicates under back-pressure.
  - FLUSH_TLB: fetchHalt=1, tlbFlush=1 until tlbFlushDone. On tlbFlushDone → DONE; tlbFlush drops the same cycle the state changes.
  - DONE: done=1 for one cycle; fetchHalt still 1. Next state is DRAIN if any pending bit is set, else IDLE.
- busy = (state != IDLE).
- Sequencing rules:
  - Requests arriving mid-sequence after their phase has passed are serviced by a further full pass, with a separate done pulse.
  - Requests arriving before their phase starts are merged into the current pass.
- fetchIdle dropping during INV_ICACHE/FLUSH_TLB is ignored; fetchHalt guarantees no new traffic.
- Reset asserted mid-walk: immediately IDLE, outputs 0, pending lost. Execute is reset too.
- tlbFlushDone or iCacheInvReady outside their states: ignored.

Optional Feature:
FETCH_INV_PERF_COUNTER_EN
- Defined: adds output port invCycleCount [31:0], which counts cycles with busy=1. Saturates at 0xFFFFFFFF and resets to 0 on rstN.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package (CacheTypes): the fetch_inv_state_t enum (IDLE, DRAIN, INV_ICACHE, FLUSH_TLB, DONE) and the icache_index_t typedef sized from the common I-cache index constant. INDEX_WIDTH defaults to that constant.
- No sub-module is required. The index walker (counter + last detect) is written inline.

Test Plan (INDEX_WIDTH=2 unless noted):
- reqICache pulse, fetchIdle=1, ready=1 constantly → indices 0,1,2,3 on consecutive cycles, no tlbFlush, done pulses once. Total IDLE→IDLE is 7 cycles; busy high for 6.
- reqICache with ready toggling 1,0,1,0… → each index 0..3 accepted exactly once in order. iCacheInvIndex is stable while ready=0.
- reqICache and reqTlb in the same cycle; fetchIdle held 0 for 5 cycles → fetchHalt=1 with no invalidate until fetchIdle rises. Then a 4-index walk, then tlbFlush held until a tlbFlushDone injected 3 cycles later, then a single done.
- reqTlb only, then reqICache pulsed during FLUSH_TLB → first done, then a second DRAIN→INV_ICACHE pass with a second done, and no intervening IDLE cycle.
- rstN pulled low while the index counter is 2 → all outputs 0 asynchronously. After release, busy=0 and no done pulse.
- With FETCH_INV_PERF_COUNTER_EN defined: after the first scenario, invCycleCount=6. Forcing the counter to 0xFFFFFFFE and running a sequence → it saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/fetch_invalidate_controller_pkg.sv
// Shared I-cache types for the fetch invalidate controller: sequencer states and line index type.
package fetch_invalidate_controller_pkg;

   localparam int unsigned ICACHE_INDEX_WIDTH = 6;

   typedef logic [ICACHE_INDEX_WIDTH-1:0] icache_index_t;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StInvICache,
      StFlushTlb,
      StDone
   } fetch_inv_state_t;

endpackage

// File: rtl/fetch_invalidate_controller.sv
// Sequences FENCE.I / SFENCE.VMA: halt and drain fetch, walk every I-cache index, flush I-TLB.
// Optional FETCH_INV_PERF_COUNTER_EN adds invCycleCount, a saturating count of busy cycles.
module fetch_invalidate_controller
   import fetch_invalidate_controller_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   reqICache,
   input  logic                   reqTlb,
   output logic                   busy,
   output logic                   done,
   output logic                   fetchHalt,
   input  logic                   fetchIdle,
   output logic                   iCacheInvValid,
   output logic [INDEX_WIDTH-1:0] iCacheInvIndex,
   input  logic                   iCacheInvReady,
   output logic                   tlbFlush,
   input  logic                   tlbFlushDone
`ifdef FETCH_INV_PERF_COUNTER_EN
   ,
   output logic [31:0]            invCycleCount
`endif
);

   fetch_inv_state_t       r_state;
   fetch_inv_state_t       w_state_d;
   logic                   r_pend_icache;
   logic                   r_pend_tlb;
   logic [INDEX_WIDTH-1:0] r_count;
   logic                   w_last;
   logic                   w_enter_inv;
   logic                   w_enter_tlb;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_fetch_halt;
   logic                   r_inv_valid;
   logic                   r_tlb_flush;

   assign w_last      = (r_count == {INDEX_WIDTH{1'b1}});
   assign w_enter_inv = (w_state_d == StInvICache) && (r_state != StInvICache);
   assign w_enter_tlb = (w_state_d == StFlushTlb) && (r_state != StFlushTlb);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (r_pend_icache || r_pend_tlb || reqICache || reqTlb) w_state_d = StDrain;
         end
         StDrain: begin
            if (fetchIdle) w_state_d = r_pend_icache ? StInvICache : StFlushTlb;
         end
         StInvICache: begin
            if (iCacheInvReady && w_last) w_state_d = r_pend_tlb ? StFlushTlb : StDone;
         end
         StFlushTlb: begin
            if (tlbFlushDone) w_state_d = StDone;
         end
         StDone: begin
            w_state_d = (r_pend_icache || r_pend_tlb) ? StDrain : StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state       <= StIdle;
         r_pend_icache <= 1'b0;
         r_pend_tlb    <= 1'b0;
         r_count       <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_fetch_halt  <= 1'b0;
         r_inv_valid   <= 1'b0;
         r_tlb_flush   <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         // A request in the same cycle as its phase entry survives for a further pass.
         r_pend_icache <= reqICache | (r_pend_icache & ~w_enter_inv);
         r_pend_tlb    <= reqTlb | (r_pend_tlb & ~w_enter_tlb);
         if (w_enter_inv) begin
            r_count <= '0;
         end else if ((r_state == StInvICache) && iCacheInvReady) begin
            r_count <= r_count + 1'b1;
         end
         r_busy       <= (w_state_d != StIdle);
         r_done       <= (w_state_d == StDone);
         r_fetch_halt <= (w_state_d != StIdle);
         r_inv_valid  <= (w_state_d == StInvICache);
         r_tlb_flush  <= (w_state_d == StFlushTlb);
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign fetchHalt      = r_fetch_halt;
   assign iCacheInvValid = r_inv_valid;
   assign iCacheInvIndex = r_count;
   assign tlbFlush       = r_tlb_flush;

`ifdef FETCH_INV_PERF_COUNTER_EN
   logic [31:0] r_cycle_count;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cycle_count <= '0;
      end else if (r_busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

   assign invCycleCount = r_cycle_count;
`endif

endmodule
